// File: rtl/instr_fetch_timing.sv
// Machine-cycle sequencer and instruction fetch for a 4-bit CPU: drives the PC a nibble at a
// time, latches OPR/OPA, and captures the second word of two-word instructions.
module instr_fetch_timing #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                runEn,
    input  logic [3:0]          romData,
    input  logic                pcLoad,
    input  logic [PC_WIDTH-1:0] pcLoadAddr,
    output logic [2:0]          cycle,
    output logic                sync,
    output logic [3:0]          romAddr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          opr,
    output logic [3:0]          opa,
    output logic [7:0]          operand2,
    output logic                secondWord,
    output logic                instrDone
);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} cycle_e;
    typedef enum logic {WORD_FIRST, WORD_SECOND} word_e;

    cycle_e              cycle_q, cycle_d;
    word_e               word_q, word_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]          opr_q, opr_d;
    logic [3:0]          opa_q, opa_d;
    logic [7:0]          operand2_q, operand2_d;
    logic                done_q, done_d;
    logic                two_word;
    logic                final_word;

    // JCN, JUN, JMS, ISZ and FIM (opr 2 with even opa) carry a second ROM word.
    assign two_word   = (opr_q inside {4'h1, 4'h4, 4'h5, 4'h7}) || ((opr_q == 4'h2) && !opa_q[0]);
    assign final_word = (word_q == WORD_SECOND) || !two_word;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path infers a latch.
        cycle_d    = cycle_q;
        word_d     = word_q;
        pc_d       = pc_q;
        opr_d      = opr_q;
        opa_d      = opa_q;
        operand2_d = operand2_q;
        done_d     = done_q;
        if (runEn) begin
            cycle_d = cycle_e'(cycle_q + 3'd1);
            done_d  = 1'b0;
            case (cycle_q)
                M1: begin
                    if (word_q == WORD_FIRST) opr_d = romData;
                    else                      operand2_d[7:4] = romData;
                end
                M2: begin
                    if (word_q == WORD_FIRST) opa_d = romData;
                    else                      operand2_d[3:0] = romData;
                end
                // opr/opa are already latched here, so the final-word pulse can be registered.
                X2: done_d = final_word;
                X3: begin
                    pc_d   = (final_word && pcLoad) ? pcLoadAddr : pc_q + PC_WIDTH'(1);
                    word_d = (word_q == WORD_FIRST && two_word) ? WORD_SECOND : WORD_FIRST;
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state, including opr/opa/operand2, is reset so an abort leaves a clean NOP.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycle_q    <= A1;
            word_q     <= WORD_FIRST;
            pc_q       <= RESET_PC;
            opr_q      <= 4'h0;
            opa_q      <= 4'h0;
            operand2_q <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cycle_q    <= cycle_d;
            word_q     <= word_d;
            pc_q       <= pc_d;
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            operand2_q <= operand2_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        romAddr = 4'h0;
        case (cycle_q)
            A1:      romAddr = pc_q[3:0];
            A2:      romAddr = pc_q[7:4];
            A3:      romAddr = pc_q[11:8];
            default: ;
        endcase
    end

    assign cycle      = cycle_q;
    assign sync       = (cycle_q == X3);
    assign pc         = pc_q;
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign operand2   = operand2_q;
    assign secondWord = (word_q == WORD_SECOND);
    assign instrDone  = done_q;

endmodule

// File: tb/tb_instr_fetch_timing.sv
// Directed bench for instr_fetch_timing: a ROM model answers the DUT's nibble addresses and a
// scoreboard of per-instruction expectations is checked on every instrDone pulse.
module tb_instr_fetch_timing;

    typedef struct {
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic [7:0]  op2;
        logic [11:0] pc_done;
        logic [11:0] pc_after;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        runEn;
    logic [3:0]  romData;
    logic        pcLoad;
    logic [11:0] pcLoadAddr;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  romAddr;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  operand2;
    logic        secondWord;
    logic        instrDone;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        pc_pending = 1'b0;
    logic [11:0] pend_pc = 12'h000;
    logic [7:0]  mem [4096];
    logic [11:0] fetch_addr = 12'h000;

    instr_fetch_timing #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .runEn      (runEn),
        .romData    (romData),
        .pcLoad     (pcLoad),
        .pcLoadAddr (pcLoadAddr),
        .cycle      (cycle),
        .sync       (sync),
        .romAddr    (romAddr),
        .pc         (pc),
        .opr        (opr),
        .opa        (opa),
        .operand2   (operand2),
        .secondWord (secondWord),
        .instrDone  (instrDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM answers the address the DUT assembled during A1..A3.
    assign romData = (cycle == 3'd3) ? mem[fetch_addr][7:4] :
                     (cycle == 3'd4) ? mem[fetch_addr][3:0] : 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_exp(input logic [3:0] o, input logic [3:0] a, input logic [7:0] op2,
                            input logic [11:0] pd, input logic [11:0] pa);
        exp_t e;
        e.opr      = o;
        e.opa      = a;
        e.op2      = op2;
        e.pc_done  = pd;
        e.pc_after = pa;
        sb_q.push_back(e);
    endtask

    // ROM address capture and scoreboard monitor.
    always @(negedge clk) begin
        case (cycle)
            3'd0:    fetch_addr[3:0]  = romAddr;
            3'd1:    fetch_addr[7:4]  = romAddr;
            3'd2:    fetch_addr[11:8] = romAddr;
            default: ;
        endcase
        if (pc_pending) begin
            check("pc_after_done", 32'(pc), 32'(pend_pc));
            pc_pending = 1'b0;
        end
        if (rstN && instrDone) begin
            check("sb_entry_available", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("done_cycle", 32'(cycle), 7);
                check("done_opr", 32'(opr), 32'(mon_e.opr));
                check("done_opa", 32'(opa), 32'(mon_e.opa));
                check("done_operand2", 32'(operand2), 32'(mon_e.op2));
                check("done_pc", 32'(pc), 32'(mon_e.pc_done));
                pend_pc    = mon_e.pc_after;
                pc_pending = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'hD5;
        mem[12'h010] = 8'h43;
        mem[12'h011] = 8'h21;
        mem[12'h321] = 8'h24;
        mem[12'h322] = 8'hAB;
        mem[12'h323] = 8'h25;
        mem[12'h002] = 8'h56;
        mem[12'h003] = 8'h78;

        rstN       = 1'b0;
        runEn      = 1'b0;
        pcLoad     = 1'b0;
        pcLoadAddr = 12'h000;
        #3;
        check("rst_cycle", 32'(cycle), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_opr", 32'(opr), 0);
        check("rst_opa", 32'(opa), 0);
        check("rst_operand2", 32'(operand2), 0);
        check("rst_second", 32'(secondWord), 0);
        check("rst_done", 32'(instrDone), 0);
        check("rst_sync", 32'(sync), 0);
        @(negedge clk);
        rstN  = 1'b1;
        runEn = 1'b1;

        // LDM 5 at 000
        push_exp(4'hD, 4'h5, 8'h00, 12'h000, 12'h001);
        check("a1_addr_000", 32'(romAddr), 0);
        tick();
        check("a2_addr_000", 32'(romAddr), 0);
        tick();
        check("a3_addr_000", 32'(romAddr), 0);
        ticks(3);
        check("x1_cycle", 32'(cycle), 5);
        check("x1_opr", 32'(opr), 32'hD);
        check("x1_opa", 32'(opa), 32'h5);
        ticks(2);
        check("x3_sync", 32'(sync), 1);
        check("x3_done", 32'(instrDone), 1);
        tick();
        check("pc_after_ldm", 32'(pc), 32'h001);
        check("sync_low_a1", 32'(sync), 0);

        // NOP at 001 with a taken jump to 010
        pcLoad     = 1'b1;
        pcLoadAddr = 12'h010;
        push_exp(4'h0, 4'h0, 8'h00, 12'h001, 12'h010);
        ticks(8);
        check("pc_jump_010", 32'(pc), 32'h010);

        // JUN 321: pcLoad held high on both words
        pcLoadAddr = 12'h321;
        push_exp(4'h4, 4'h3, 8'h21, 12'h011, 12'h321);
        ticks(7);
        check("jun_w1_done_low", 32'(instrDone), 0);
        check("jun_w1_second_low", 32'(secondWord), 0);
        tick();
        check("jun_w1_pc_inc", 32'(pc), 32'h011);
        check("jun_w2_second", 32'(secondWord), 1);
        ticks(5);
        check("jun_operand2", 32'(operand2), 32'h21);
        check("jun_opr_held", 32'(opr), 32'h4);
        check("jun_opa_held", 32'(opa), 32'h3);
        check("jun_w2_second_x1", 32'(secondWord), 1);
        ticks(2);
        check("jun_w2_done", 32'(instrDone), 1);
        tick();
        check("jun_pc_target", 32'(pc), 32'h321);
        check("jun_second_clear", 32'(secondWord), 0);
        pcLoad = 1'b0;

        // FIM (opr 2, even opa) is two-word
        push_exp(4'h2, 4'h4, 8'hAB, 12'h322, 12'h323);
        ticks(8);
        check("fim_second", 32'(secondWord), 1);
        ticks(8);
        check("fim_pc", 32'(pc), 32'h323);

        // SRC (opr 2, odd opa) is single-word
        push_exp(4'h2, 4'h5, 8'hAB, 12'h323, 12'h324);
        ticks(7);
        check("src_done", 32'(instrDone), 1);
        tick();
        check("src_second_low", 32'(secondWord), 0);
        check("src_pc", 32'(pc), 32'h324);

        // NOP at 324 jumping to FFF, then NOP at FFF wrapping to 000
        pcLoad     = 1'b1;
        pcLoadAddr = 12'hFFF;
        push_exp(4'h0, 4'h0, 8'hAB, 12'h324, 12'hFFF);
        ticks(8);
        check("pc_fff", 32'(pc), 32'hFFF);
        pcLoad = 1'b0;
        push_exp(4'h0, 4'h0, 8'hAB, 12'hFFF, 12'h000);
        check("fff_a1_addr", 32'(romAddr), 32'hF);
        tick();
        check("fff_a2_addr", 32'(romAddr), 32'hF);
        tick();
        check("fff_a3_addr", 32'(romAddr), 32'hF);
        ticks(6);
        check("pc_wrap", 32'(pc), 32'h000);

        // LDM 5 at 000 with a five-clock freeze at M1
        push_exp(4'hD, 4'h5, 8'hAB, 12'h000, 12'h001);
        ticks(3);
        runEn = 1'b0;
        ticks(5);
        check("frz_cycle", 32'(cycle), 3);
        check("frz_opr", 32'(opr), 0);
        check("frz_pc", 32'(pc), 0);
        runEn = 1'b1;
        tick();
        check("resume_cycle", 32'(cycle), 4);
        check("resume_opr", 32'(opr), 32'hD);
        tick();
        check("resume_opa", 32'(opa), 32'h5);
        ticks(2);
        check("resume_done", 32'(instrDone), 1);
        tick();
        check("resume_pc", 32'(pc), 32'h001);

        // NOP at 001, then JMS at 002 aborted by reset during X2 of its second word
        push_exp(4'h0, 4'h0, 8'hAB, 12'h001, 12'h002);
        ticks(8);
        check("jms_pc", 32'(pc), 32'h002);
        ticks(8);
        check("jms_second", 32'(secondWord), 1);
        check("jms_pc_w2", 32'(pc), 32'h003);
        ticks(6);
        check("jms_cycle_x2", 32'(cycle), 6);
        check("jms_operand2", 32'(operand2), 32'h78);
        #2;
        rstN = 1'b0;
        #1;
        check("abort_cycle", 32'(cycle), 0);
        check("abort_pc", 32'(pc), 0);
        check("abort_second", 32'(secondWord), 0);
        check("abort_opr", 32'(opr), 0);
        check("abort_opa", 32'(opa), 0);
        check("abort_operand2", 32'(operand2), 0);
        check("abort_done", 32'(instrDone), 0);
        tick();
        check("abort_hold_cycle", 32'(cycle), 0);
        @(negedge clk);
        rstN = 1'b1;

        // Fresh FIRST-word fetch at 000
        push_exp(4'hD, 4'h5, 8'h00, 12'h000, 12'h001);
        check("post_rst_addr", 32'(romAddr), 0);
        check("post_rst_second", 32'(secondWord), 0);
        tick();
        ticks(6);
        check("post_rst_done", 32'(instrDone), 1);
        tick();
        check("post_rst_pc", 32'(pc), 32'h001);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
